// File: rtl/i2c_init_sequencer.sv
// Boot-time command sequencer: walks a {dev_addr, reg, data} table and issues
// each write entry to the I2C master, with delay entries, end marker and NACK retry.
module i2c_init_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int DELAY_UNIT  = 125000,
  parameter int MAX_RETRIES = 3,
  parameter int RETRY_GAP   = 12500,
  parameter int AUTO_RUN    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic              i2c_start,
  output logic [23:0]       i2c_data,
  input  logic              i2c_busy,
  input  logic              i2c_ack_error,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] error_index
);

  localparam int TICK_W = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
  localparam int GAP_W  = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
  localparam int RTY_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DELAY_UNIT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RETRY_GAP - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRIES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_ISSUE     = 4'd3;
  localparam logic [3:0] S_WAIT_BUSY = 4'd4;
  localparam logic [3:0] S_WAIT_DONE = 4'd5;
  localparam logic [3:0] S_GAP       = 4'd6;
  localparam logic [3:0] S_DELAY     = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;
  localparam logic [3:0] S_FAIL      = 4'd9;

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] eidx_q, eidx_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [2:0]        wd_q, wd_d;
  logic              auto_q;
  logic              advance, finish, fail, restart;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    eidx_d  = eidx_q;
    retry_d = retry_q;
    tick_d  = tick_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    wd_d    = wd_q;
    advance = 1'b0;
    finish  = 1'b0;
    fail    = 1'b0;
    restart = 1'b0;

    case (state_q)
      S_IDLE:   if (run || (AUTO_RUN != 0 && auto_q)) restart = 1'b1;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (rom_data[23:16] == 8'hFF) begin
          finish = 1'b1;
        end else if (rom_data[23:16] == 8'hFE) begin
          if (rom_data[15:0] == 16'd0) begin
            advance = 1'b1;
          end else begin
            cnt_d   = rom_data[15:0];
            tick_d  = TICK_LAST;
            state_d = S_DELAY;
          end
        end else begin
          data_d  = rom_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT_BUSY;
      end
      // Timeout fires on the 7th idle WAIT_BUSY cycle so error shows 8 cycles after start.
      S_WAIT_BUSY: begin
        if (i2c_busy)            state_d = S_WAIT_DONE;
        else if (wd_q == 3'd6)   fail    = 1'b1;
        else                     wd_d    = wd_q + 3'd1;
      end
      S_WAIT_DONE: begin
        if (!i2c_busy) begin
          if (!i2c_ack_error) begin
            retry_d = '0;
            advance = 1'b1;
          end else if (retry_q < RTY_MAX) begin
            retry_d = retry_q + 1'b1;
            gap_d   = GAP_LAST;
            state_d = S_GAP;
          end else begin
            fail = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_ISSUE;
        else             gap_d   = gap_q - 1'b1;
      end
      // Tick counter wraps every DELAY_UNIT cycles; the tick count is consumed per wrap.
      S_DELAY: begin
        if (tick_q != '0) begin
          tick_d = tick_q - 1'b1;
        end else if (cnt_q == 16'd1) begin
          cnt_d   = '0;
          advance = 1'b1;
        end else begin
          cnt_d  = cnt_q - 16'd1;
          tick_d = TICK_LAST;
        end
      end
      S_DONE, S_FAIL: if (run) restart = 1'b1;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (addr_q == LAST_ADDR) begin
        finish = 1'b1;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = S_FETCH;
      end
    end
    if (finish) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
    end
    if (fail) begin
      state_d = S_FAIL;
      error_d = 1'b1;
      eidx_d  = addr_q;
      busy_d  = 1'b0;
    end
    if (restart) begin
      state_d = S_FETCH;
      addr_d  = '0;
      done_d  = 1'b0;
      error_d = 1'b0;
      retry_d = '0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      eidx_q  <= '0;
      retry_q <= '0;
      tick_q  <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      wd_q    <= '0;
      auto_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      eidx_q  <= eidx_d;
      retry_q <= retry_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      wd_q    <= wd_d;
      auto_q  <= 1'b0;
    end
  end

  assign rom_addr    = addr_q;
  assign i2c_start   = (state_q == S_ISSUE);
  assign i2c_data    = data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign error_index = eidx_q;

endmodule
